// File: rtl/bp_nonsynth_cosim_sched.sv
// Co-simulation step scheduler.
//
// Arbitrates per-core commit/trap records onto the single step channel that
// feeds the reference-model checker. Round-robin grant, single-entry output
// register, global retired-instruction counter and sticky pass/fail status.
//
// Ports:
//   clk_i, reset_i     clock, asynchronous active-low reset
//   en_i               cosim enable; low blocks new grants
//   instr_limit_i      pass threshold on retired commits (0 = no limit)
//   req_*              per-core record valid/ready and payload (core i at slice i)
//   step_v_o/_yumi_i   registered step record and checker consume
//   step_fail_i        checker mismatch, qualified by step_yumi_i
//   step_*_o           step payload (source hart, trap flag, pc, instr, data/cause)
//   instr_cnt_o        retired commit count (saturating)
//   pass_o, fail_o     sticky terminal status

module bp_nonsynth_cosim_sched #(
    parameter int unsigned num_core_p    = 4,
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned instr_width_p = 32,
    parameter int unsigned dword_width_p = 64,
    parameter int unsigned cnt_width_p   = 32,
    localparam int unsigned hart_w       = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              en_i,
    input  logic [cnt_width_p-1:0]            instr_limit_i,

    input  logic [num_core_p-1:0]             req_v_i,
    output logic [num_core_p-1:0]             req_ready_o,
    input  logic [num_core_p-1:0]             req_trap_i,
    input  logic [num_core_p*vaddr_width_p-1:0] req_pc_i,
    input  logic [num_core_p*instr_width_p-1:0] req_instr_i,
    input  logic [num_core_p*dword_width_p-1:0] req_data_i,

    output logic                              step_v_o,
    input  logic                              step_yumi_i,
    input  logic                              step_fail_i,
    output logic [hart_w-1:0]                 step_hart_o,
    output logic                              step_trap_o,
    output logic [vaddr_width_p-1:0]          step_pc_o,
    output logic [instr_width_p-1:0]          step_instr_o,
    output logic [dword_width_p-1:0]          step_data_o,

    output logic [cnt_width_p-1:0]            instr_cnt_o,
    output logic                              pass_o,
    output logic                              fail_o
);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StPass, StFail} state_e;

    state_e state_q, state_d;

    logic                     step_v_q, step_v_d;
    logic [hart_w-1:0]        hart_q, hart_d;
    logic                     trap_q, trap_d;
    logic [vaddr_width_p-1:0] pc_q, pc_d;
    logic [instr_width_p-1:0] instr_q, instr_d;
    logic [dword_width_p-1:0] data_q, data_d;
    logic [cnt_width_p-1:0]   cnt_q, cnt_d;
    logic [hart_w-1:0]        ptr_q, ptr_d;

    logic              slot_free;
    logic              fail_evt;
    logic              cnt_inc;
    logic              limit_hit;
    logic              grant_ok;
    logic              found;
    logic              grant;
    logic [hart_w-1:0] win_idx;
    int                idx;

    always_comb begin
        slot_free = ~step_v_q | step_yumi_i;
        fail_evt  = step_yumi_i & step_fail_i & (state_q != StPass);

        // Only a valid, non-failing commit retires; traps do not count.
        cnt_inc = step_yumi_i & step_v_q & ~trap_q & ~step_fail_i;
        cnt_d   = cnt_q;
        if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + cnt_width_p'(1);
        end

        limit_hit = (state_q == StRun) && (instr_limit_i != '0) && (cnt_d >= instr_limit_i);

        // A failing cycle also suppresses the grant so no accepted record is dropped.
        grant_ok = (state_q == StRun) & en_i & slot_free & ~limit_hit & ~fail_evt;

        // Rotating priority search starting at the round-robin pointer.
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int off = 0; off < int'(num_core_p); off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= int'(num_core_p)) begin
                idx = idx - int'(num_core_p);
            end
            if (!found && req_v_i[idx]) begin
                found   = 1'b1;
                win_idx = hart_w'(idx);
            end
        end
        grant = grant_ok & found;

        req_ready_o = '0;
        if (grant) begin
            req_ready_o[win_idx] = 1'b1;
        end

        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (int'(win_idx) == int'(num_core_p) - 1) ? '0 : win_idx + hart_w'(1);
        end

        hart_d  = hart_q;
        trap_d  = trap_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        data_d  = data_q;
        for (int i = 0; i < int'(num_core_p); i++) begin
            if (grant && (int'(win_idx) == i)) begin
                hart_d  = win_idx;
                trap_d  = req_trap_i[i];
                pc_d    = req_pc_i[i*vaddr_width_p +: vaddr_width_p];
                instr_d = req_instr_i[i*instr_width_p +: instr_width_p];
                data_d  = req_data_i[i*dword_width_p +: dword_width_p];
            end
        end

        if (fail_evt || (state_q == StFail)) begin
            step_v_d = 1'b0;
        end else if (grant) begin
            step_v_d = 1'b1;
        end else if (step_yumi_i) begin
            step_v_d = 1'b0;
        end else begin
            step_v_d = step_v_q;
        end

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en_i) state_d = StRun;
            StRun:   if (limit_hit) state_d = StDrain;
            StDrain: if (!step_v_q) state_d = StPass;
            StPass:  state_d = StPass;
            StFail:  state_d = StFail;
            default: state_d = StIdle;
        endcase
        // Fail outranks a same-cycle limit hit.
        if (fail_evt) begin
            state_d = StFail;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= StIdle;
            step_v_q <= 1'b0;
            hart_q   <= '0;
            trap_q   <= 1'b0;
            pc_q     <= '0;
            instr_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_v_q <= step_v_d;
            hart_q   <= hart_d;
            trap_q   <= trap_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign step_v_o     = step_v_q;
    assign step_hart_o  = hart_q;
    assign step_trap_o  = trap_q;
    assign step_pc_o    = pc_q;
    assign step_instr_o = instr_q;
    assign step_data_o  = data_q;
    assign instr_cnt_o  = cnt_q;
    assign pass_o       = (state_q == StPass);
    assign fail_o       = (state_q == StFail);

endmodule

// File: tb/tb_bp_nonsynth_cosim_sched.sv
// Directed bench for bp_nonsynth_cosim_sched: a per-cycle vector table for the
// arbitration/backpressure stream plus hand-written trap, reset, limit and fail
// sequences.

module tb_bp_nonsynth_cosim_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned VW = 39;
    localparam int unsigned IW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 32;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              en_i;
    logic [CW-1:0]     instr_limit_i;
    logic [N-1:0]      req_v_i;
    logic [N-1:0]      req_ready_o;
    logic [N-1:0]      req_trap_i;
    logic [N*VW-1:0]   req_pc_i;
    logic [N*IW-1:0]   req_instr_i;
    logic [N*DW-1:0]   req_data_i;
    logic              step_v_o;
    logic              step_yumi_i;
    logic              step_fail_i;
    logic [1:0]        step_hart_o;
    logic              step_trap_o;
    logic [VW-1:0]     step_pc_o;
    logic [IW-1:0]     step_instr_o;
    logic [DW-1:0]     step_data_o;
    logic [CW-1:0]     instr_cnt_o;
    logic              pass_o;
    logic              fail_o;

    bp_nonsynth_cosim_sched #(
        .num_core_p   (N),
        .vaddr_width_p(VW),
        .instr_width_p(IW),
        .dword_width_p(DW),
        .cnt_width_p  (CW)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .instr_limit_i(instr_limit_i),
        .req_v_i      (req_v_i),
        .req_ready_o  (req_ready_o),
        .req_trap_i   (req_trap_i),
        .req_pc_i     (req_pc_i),
        .req_instr_i  (req_instr_i),
        .req_data_i   (req_data_i),
        .step_v_o     (step_v_o),
        .step_yumi_i  (step_yumi_i),
        .step_fail_i  (step_fail_i),
        .step_hart_o  (step_hart_o),
        .step_trap_o  (step_trap_o),
        .step_pc_o    (step_pc_o),
        .step_instr_o (step_instr_o),
        .step_data_o  (step_data_o),
        .instr_cnt_o  (instr_cnt_o),
        .pass_o       (pass_o),
        .fail_o       (fail_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          en;
        logic [N-1:0]  rv;
        logic          yumi;
        logic [N-1:0]  exp_ready;
        logic          exp_v;
        logic [1:0]    exp_hart;
        logic [CW-1:0] exp_cnt;
        logic [VW-1:0] exp_pc;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add(input logic en, input logic [N-1:0] rv, input logic yumi,
                       input logic [N-1:0] rdy, input logic v, input logic [1:0] hart,
                       input int cnt, input logic [VW-1:0] pc);
        vec_t t;
        t.en = en; t.rv = rv; t.yumi = yumi; t.exp_ready = rdy; t.exp_v = v;
        t.exp_hart = hart; t.exp_cnt = CW'(cnt); t.exp_pc = pc;
        vq.push_back(t);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i = 1'b0;
        en_i = 1'b0; req_v_i = '0; step_yumi_i = 1'b0; step_fail_i = 1'b0; req_trap_i = '0;
        @(negedge clk_i);
        reset_i = 1'b1;
    endtask

    int grants;
    int nyumi;
    logic late_ready;
    logic fail_seen;

    initial begin
        reset_i = 1'b0;
        en_i = 1'b0;
        instr_limit_i = '0;
        req_v_i = '0;
        req_trap_i = '0;
        step_yumi_i = 1'b0;
        step_fail_i = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            req_pc_i[i*VW +: VW]    = VW'(32'h100 * (i + 1));
            req_instr_i[i*IW +: IW] = IW'(32'h13 + i);
            req_data_i[i*DW +: DW]  = DW'(64'hd0 + i);
        end

        #1;
        check("reset step_v", 64'(step_v_o), 64'd0);
        check("reset ready", 64'(req_ready_o), 64'd0);
        check("reset cnt", 64'(instr_cnt_o), 64'd0);
        check("reset pass", 64'(pass_o), 64'd0);
        check("reset fail", 64'(fail_o), 64'd0);
        check("reset pc", 64'(step_pc_o), 64'd0);

        //   en rv    yumi rdy   v hart cnt pc
        add(1, 4'h0, 0, 4'h0, 0, 0, 0,  39'h0);
        add(1, 4'hf, 0, 4'h1, 1, 0, 0,  39'h100);
        add(1, 4'hf, 1, 4'h2, 1, 1, 1,  39'h200);
        add(1, 4'hf, 1, 4'h4, 1, 2, 2,  39'h300);
        add(1, 4'hf, 1, 4'h8, 1, 3, 3,  39'h400);
        add(1, 4'hf, 1, 4'h1, 1, 0, 4,  39'h100);
        add(1, 4'hf, 1, 4'h2, 1, 1, 5,  39'h200);
        add(1, 4'hf, 1, 4'h4, 1, 2, 6,  39'h300);
        add(1, 4'hf, 1, 4'h8, 1, 3, 7,  39'h400);
        add(1, 4'h0, 1, 4'h0, 0, 3, 8,  39'h400);
        // core 2 alone, checker stalls for 5 cycles
        add(1, 4'h4, 0, 4'h4, 1, 2, 8,  39'h300);
        for (int k = 0; k < 5; k++) add(1, 4'h4, 0, 4'h0, 1, 2, 8, 39'h300);
        add(1, 4'h4, 1, 4'h4, 1, 2, 9,  39'h300);
        add(1, 4'h4, 1, 4'h4, 1, 2, 10, 39'h300);
        add(1, 4'h0, 1, 4'h0, 0, 2, 11, 39'h300);
        // enable low blocks grants but the pending record still drains
        add(0, 4'hf, 0, 4'h0, 0, 2, 11, 39'h300);
        add(1, 4'hf, 0, 4'h8, 1, 3, 11, 39'h400);
        add(0, 4'hf, 1, 4'h0, 0, 3, 12, 39'h400);

        @(negedge clk_i);
        reset_i = 1'b1;

        foreach (vq[j]) begin
            @(negedge clk_i);
            en_i = vq[j].en; req_v_i = vq[j].rv; step_yumi_i = vq[j].yumi;
            #1;
            check($sformatf("v%0d ready", j), 64'(req_ready_o), 64'(vq[j].exp_ready));
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d step_v", j), 64'(step_v_o), 64'(vq[j].exp_v));
            check($sformatf("v%0d hart", j), 64'(step_hart_o), 64'(vq[j].exp_hart));
            check($sformatf("v%0d cnt", j), 64'(instr_cnt_o), 64'(vq[j].exp_cnt));
            check($sformatf("v%0d pc", j), 64'(step_pc_o), 64'(vq[j].exp_pc));
        end

        // Trap record from core 1 (pointer is at 0, so core 1 wins).
        @(negedge clk_i);
        en_i = 1'b1; step_yumi_i = 1'b0; req_v_i = 4'h2; req_trap_i = 4'h2;
        req_data_i[1*DW +: DW] = 64'h8000_0000_0000_0007;
        #1;
        check("trap ready", 64'(req_ready_o), 64'h2);
        @(posedge clk_i);
        #1;
        check("trap v", 64'(step_v_o), 64'd1);
        check("trap flag", 64'(step_trap_o), 64'd1);
        check("trap cause", step_data_o, 64'h8000_0000_0000_0007);
        check("trap hart", 64'(step_hart_o), 64'd1);
        @(negedge clk_i);
        req_v_i = '0; req_trap_i = '0; step_yumi_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("trap not counted", 64'(instr_cnt_o), 64'd12);
        check("trap consumed", 64'(step_v_o), 64'd0);

        // Asynchronous reset with a record pending.
        @(negedge clk_i);
        step_yumi_i = 1'b0; req_v_i = 4'hf;
        @(posedge clk_i);
        #1;
        check("pre-reset v", 64'(step_v_o), 64'd1);
        #2;
        reset_i = 1'b0;
        #1;
        check("async reset v", 64'(step_v_o), 64'd0);
        check("async reset cnt", 64'(instr_cnt_o), 64'd0);
        check("async reset hart", 64'(step_hart_o), 64'd0);
        check("async reset ready", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b1; en_i = 1'b1; req_v_i = 4'hf;
        @(negedge clk_i);
        #1;
        check("post-reset first grant", 64'(req_ready_o), 64'h1);
        @(posedge clk_i);
        #1;
        check("post-reset hart", 64'(step_hart_o), 64'd0);

        // Instruction limit of 5 with cores 0 and 1 requesting.
        do_reset();
        instr_limit_i = 32'd5; en_i = 1'b1; req_v_i = 4'h3;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            step_yumi_i = step_v_o;
            #1;
            grants += $countones(req_ready_o);
            @(posedge clk_i);
        end
        #1;
        check("limit grants", 64'(grants), 64'd5);
        check("limit cnt", 64'(instr_cnt_o), 64'd5);
        check("limit pass", 64'(pass_o), 64'd1);
        check("limit no fail", 64'(fail_o), 64'd0);
        check("limit step_v", 64'(step_v_o), 64'd0);

        // Checker fail on the 3rd record with the limit at 3.
        do_reset();
        instr_limit_i = 32'd3; en_i = 1'b1; req_v_i = 4'h1;
        nyumi = 0; late_ready = 1'b0; fail_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            step_yumi_i = step_v_o;
            step_fail_i = step_v_o && (nyumi == 2);
            #1;
            if (fail_seen) late_ready = late_ready | (|req_ready_o);
            if (step_yumi_i) nyumi++;
            @(posedge clk_i);
            #1;
            if (step_fail_i) begin
                fail_seen = 1'b1;
                check("fail next cycle", 64'(fail_o), 64'd1);
            end
        end
        check("fail sticky", 64'(fail_o), 64'd1);
        check("fail no pass", 64'(pass_o), 64'd0);
        check("fail no ready", 64'(late_ready), 64'd0);
        check("fail cnt", 64'(instr_cnt_o), 64'd2);
        check("fail step_v", 64'(step_v_o), 64'd0);
        check("fail yumis", 64'(nyumi), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bp_nonsynth_cosim_sched.md
Name: bp_nonsynth_cosim_sched

Overview:
- Arbitrates per-core commit/trap records from num_core_p cores onto a single step channel that feeds the co-simulation reference-model checker.
- The checker accepts at most one record per cycle.
- The block owns the global retired-instruction count, the instruction-limit pass condition and the sticky fail condition.
- It sits between the per-core commit FIFOs and the DPI step/trap caller.

Parameters:
- num_core_p, 4, number of requesting cores; legal range 1..16.
- vaddr_width_p, 39, PC width.
- instr_width_p, 32, instruction width.
- dword_width_p, 64, writeback data and cause width.
- cnt_width_p, 32, retired-instruction counter width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-low.
- en_i  in  1  cosim enable; low blocks new grants.
- instr_limit_i  in  cnt_width_p  pass threshold; 0 disables the limit.
- req_v_i  in  num_core_p  per-core record valid.
- req_ready_o  out  num_core_p  per-core accept; at most one bit high.
- req_trap_i  in  num_core_p  record is a trap rather than a commit.
- req_pc_i  in  num_core_p*vaddr_width_p  commit PC, core i at slice i.
- req_instr_i  in  num_core_p*instr_width_p  commit instruction.
- req_data_i  in  num_core_p*dword_width_p  writeback data for a commit, cause for a trap.
- step_v_o  out  1  step record valid.
- step_yumi_i  in  1  checker consumes the record.
- step_fail_i  in  1  checker mismatch, valid only with step_yumi_i.
- step_hart_o  out  clog2(num_core_p), min 1  source core.
- step_trap_o  out  1  trap flag.
- step_pc_o  out  vaddr_width_p  PC.
- step_instr_o  out  instr_width_p  instruction.
- step_data_o  out  dword_width_p  data or cause.
- instr_cnt_o  out  cnt_width_p  retired commits.
- pass_o  out  1  sticky pass.
- fail_o  out  1  sticky fail.

Behaviour:
- Reset values: state IDLE, step_v_o=0, req_ready_o=0, rr pointer=0, instr_cnt_o=0, pass_o=0, fail_o=0. Step payload registers reset to 0.
- States: IDLE, RUN, DRAIN, PASS, FAIL.
  - IDLE->RUN when en_i=1.
  - RUN->DRAIN when the limit is hit.
  - DRAIN->PASS when step_v_o=0.
  - Any state except PASS->FAIL on step_yumi_i&step_fail_i.
  - PASS and FAIL are terminal until reset.
- Output stage: single-entry register. A slot is free when step_v_o=0 or step_yumi_i=1 in the current cycle.
- Grant: only in RUN with en_i=1 and a free slot.
  - Winner = first i with req_v_i[i]=1, searching from the rr pointer upward with wrap.
  - req_ready_o[winner]=1 combinationally in the same cycle.
  - The winner's record is loaded and step_v_o=1 from the next cycle, so latency is 1 cycle.
  - The rr pointer moves to winner+1 mod num_core_p.
  - No grant means the pointer holds.
- Throughput: 1 record/cycle sustained; consume and load in the same cycle are allowed.
- Fairness: a core holding req_v_i high is granted within num_core_p grants.
- step_v_o and its payload hold stable until step_yumi_i.
- en_i=0 in RUN: no new grants; the pending step_v_o is still offered and may be consumed.
- Counter: increments on step_yumi_i & ~step_trap_o & ~step_fail_i and saturates at all-ones. Traps are not counted.
- Limit hit: instr_limit_i!=0 and the next count value >= instr_limit_i, evaluated in RUN. The grant in that same cycle is suppressed.
- Same-cycle limit hit and fail: FAIL wins, pass_o stays 0.
- In PASS/FAIL: req_ready_o=0. After a fail the pending record is not re-offered; step_v_o clears next cycle.
- An asserted reset_i mid-operation discards the pending record and returns all state to reset values.

Test Plan:
- num_core_p=4, all req_v_i=1 continuously, step_yumi_i=1 -> step_hart_o sequence 0,1,2,3,0,...; one record/cycle; instr_cnt_o=8 after 8 consumed commits.
- Only core 2 valid with 3 records, step_yumi_i held 0 for 5 cycles -> req_ready_o=0100 once, then 0000; step_pc_o stable; after yumi, remaining records issue at 1/cycle.
- instr_limit_i=5, cores 0 and 1 continuous -> state DRAIN on 5th counted yumi, no further req_ready_o, pass_o=1 next cycle with instr_cnt_o=5.
- Trap record (req_trap_i=1, data=0x8000000000000007) among commits -> step_trap_o=1 with that cause; instr_cnt_o unchanged by the trap.
- step_fail_i=1 with yumi on 3rd record -> fail_o=1 next cycle; req_ready_o=0 forever after; pass_o=0 even when the limit equals 3.
- reset_i driven low mid-stream with step_v_o=1 -> step_v_o, instr_cnt_o and pointer=0 immediately (async); after release, the first grant goes to core 0.
